// File: rtl/lamp_sequence_monitor.sv
// lamp_sequence_monitor: passive checker of one-hot lamp encoding, RED->GREEN->YELLOW order and dwell.
module lamp_sequence_monitor #(
    parameter int MIN_DWELL = 1,
    parameter int MAX_DWELL = 1,
    parameter int DWELL_W   = 4,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr_err,
    input  logic [2:0]       light,
    output logic             locked,
    output logic [1:0]       cur_color,
    output logic             err_onehot,
    output logic             err_order,
    output logic             err_dwell,
    output logic             err_sticky,
    output logic [CNT_W-1:0] cycle_count
);
    typedef enum logic {UNLOCKED, LOCKED} state_t;
    state_t state_q, state_d;
    logic [1:0] cur_color_q, cur_color_d, color;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [CNT_W-1:0] cycle_count_q, cycle_count_d;
    logic err_onehot_q, err_onehot_d, err_order_q, err_order_d;
    logic err_dwell_q, err_dwell_d, err_sticky_q, err_sticky_d;
    logic legal;
    always_comb begin
        color = light === 3'b001 ? 2'd1 : light === 3'b010 ? 2'd2 : light === 3'b100 ? 2'd3 : 2'd0;
        legal = color == (cur_color_q == 2'd3 ? 2'd1 : cur_color_q + 2'd1);
        state_d = state_q;
        cur_color_d = cur_color_q;
        dwell_d = dwell_q;
        cycle_count_d = cycle_count_q;
        err_onehot_d = 1'b0;
        err_order_d = 1'b0;
        err_dwell_d = 1'b0;
        if (!en) begin
            state_d = UNLOCKED;
            cur_color_d = 2'd0;
            dwell_d = '0;
        end else if (state_q == UNLOCKED) begin
            if (color != 2'd0) begin
                state_d = LOCKED;
                cur_color_d = color;
                dwell_d = DWELL_W'(1);
            end
        end else if (color == 2'd0) begin
            err_onehot_d = 1'b1;
            state_d = UNLOCKED;
            cur_color_d = 2'd0;
            dwell_d = '0;
        end else if (color == cur_color_q) begin
            dwell_d = &dwell_q ? dwell_q : dwell_q + DWELL_W'(1);
            err_dwell_d = dwell_q == DWELL_W'(MAX_DWELL);
        end else begin
            // illegal jumps resync onto the observed colour without touching the cycle count
            err_order_d = !legal;
            err_dwell_d = legal && dwell_q < DWELL_W'(MIN_DWELL);
            if (legal && cur_color_q == 2'd3 && !(&cycle_count_q))
                cycle_count_d = cycle_count_q + CNT_W'(1);
            cur_color_d = color;
            dwell_d = DWELL_W'(1);
        end
        err_sticky_d = err_onehot_d | err_order_d | err_dwell_d | (err_sticky_q & ~clr_err);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= UNLOCKED;
            cur_color_q <= 2'd0;
            dwell_q <= '0;
            cycle_count_q <= '0;
            err_onehot_q <= 1'b0;
            err_order_q <= 1'b0;
            err_dwell_q <= 1'b0;
            err_sticky_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cur_color_q <= cur_color_d;
            dwell_q <= dwell_d;
            cycle_count_q <= cycle_count_d;
            err_onehot_q <= err_onehot_d;
            err_order_q <= err_order_d;
            err_dwell_q <= err_dwell_d;
            err_sticky_q <= err_sticky_d;
        end
    end
    assign locked = state_q == LOCKED;
    assign cur_color = cur_color_q;
    assign err_onehot = err_onehot_q;
    assign err_order = err_order_q;
    assign err_dwell = err_dwell_q;
    assign err_sticky = err_sticky_q;
    assign cycle_count = cycle_count_q;
endmodule

// File: tb/tb_lamp_sequence_monitor.sv
// tb_lamp_sequence_monitor: two monitor configurations checked against a sequence-level reference model.
module tb_lamp_sequence_monitor;
    logic clk = 1'b0;
    logic rst = 1'b1, en = 1'b0, clr_err = 1'b0;
    logic [2:0] light = 3'b000;
    logic a_locked, a_oh, a_ord, a_dw, a_st;
    logic [1:0] a_col;
    logic [7:0] a_cnt;
    logic b_locked, b_oh, b_ord, b_dw, b_st;
    logic [1:0] b_col;
    logic [1:0] b_cnt;
    int vectors = 0, miscompares = 0;
    int p_min [2] = '{1, 2};
    int p_max [2] = '{1, 3};
    int p_cmax [2] = '{255, 3};
    bit m_lock [2];
    int m_cur [2];
    int m_run [2];
    int m_cnt [2];
    bit m_oh [2], m_ord [2], m_dw [2], m_st [2];
    always #5 clk = ~clk;
    lamp_sequence_monitor dut (
        .clk(clk), .rst(rst), .en(en), .clr_err(clr_err), .light(light),
        .locked(a_locked), .cur_color(a_col), .err_onehot(a_oh), .err_order(a_ord),
        .err_dwell(a_dw), .err_sticky(a_st), .cycle_count(a_cnt)
    );
    lamp_sequence_monitor #(.MIN_DWELL(2), .MAX_DWELL(3), .DWELL_W(4), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .en(en), .clr_err(clr_err), .light(light),
        .locked(b_locked), .cur_color(b_col), .err_onehot(b_oh), .err_order(b_ord),
        .err_dwell(b_dw), .err_sticky(b_st), .cycle_count(b_cnt)
    );
    // colours indexed 0=RED 1=GREEN 2=YELLOW; the legal successor is (c+1)%3
    task automatic model(input int i);
        int c;
        c = light === 3'b001 ? 0 : light === 3'b010 ? 1 : light === 3'b100 ? 2 : -1;
        m_oh[i] = 0; m_ord[i] = 0; m_dw[i] = 0;
        if (rst) begin
            m_lock[i] = 0; m_run[i] = 0; m_cnt[i] = 0; m_st[i] = 0;
            return;
        end
        if (!en) begin
            m_lock[i] = 0; m_run[i] = 0;
        end else if (!m_lock[i]) begin
            if (c >= 0) begin m_lock[i] = 1; m_cur[i] = c; m_run[i] = 1; end
        end else if (c < 0) begin
            m_oh[i] = 1; m_lock[i] = 0; m_run[i] = 0;
        end else if (c == m_cur[i]) begin
            m_run[i]++;
            m_dw[i] = m_run[i] == p_max[i] + 1;
        end else begin
            if (c == (m_cur[i] + 1) % 3) begin
                m_dw[i] = m_run[i] < p_min[i];
                if (m_cur[i] == 2 && m_cnt[i] < p_cmax[i]) m_cnt[i]++;
            end else m_ord[i] = 1;
            m_cur[i] = c; m_run[i] = 1;
        end
        m_st[i] = m_oh[i] | m_ord[i] | m_dw[i] | (m_st[i] & !clr_err);
    endtask
    function automatic logic [13:0] expv(input int i);
        logic [1:0] col;
        col = m_lock[i] ? 2'(m_cur[i] + 1) : 2'd0;
        return {m_lock[i], col, m_oh[i], m_ord[i], m_dw[i], m_st[i], 8'(m_cnt[i])};
    endfunction
    task automatic apply(input logic [2:0] l, input logic e, input logic c, input logic r);
        logic [13:0] oa, ob, ea, eb;
        light = l; en = e; clr_err = c; rst = r;
        @(posedge clk);
        model(0);
        model(1);
        #1;
        oa = {a_locked, a_col, a_oh, a_ord, a_dw, a_st, a_cnt};
        ob = {b_locked, b_col, b_oh, b_ord, b_dw, b_st, 6'd0, b_cnt};
        ea = expv(0);
        eb = expv(1);
        vectors += 2;
        assert (oa === ea) else begin
            miscompares++;
            $error("FAIL dflt t=%0t light=%b en=%b clr=%b rst=%b observed=%h expected=%h", $time, l, e, c, r, oa, ea);
        end
        assert (ob === eb) else begin
            miscompares++;
            $error("FAIL min2max3 t=%0t light=%b en=%b clr=%b rst=%b observed=%h expected=%h", $time, l, e, c, r, ob, eb);
        end
    endtask
    function automatic logic [2:0] onehot(input int c);
        return c == 0 ? 3'b001 : c == 1 ? 3'b010 : 3'b100;
    endfunction
    initial begin
        logic [2:0] bad [5] = '{3'b000, 3'b011, 3'b101, 3'b110, 3'b111};
        int k, base;
        apply(3'b000, 1'b0, 1'b0, 1'b1);
        apply(3'b000, 1'b0, 1'b0, 1'b1);
        for (int n = 0; n < 3; n++) begin
            apply(3'b001, 1'b1, 1'b0, 1'b0);
            apply(3'b010, 1'b1, 1'b0, 1'b0);
            apply(3'b100, 1'b1, 1'b0, 1'b0);
        end
        repeat (3) apply(3'b010, 1'b1, 1'b0, 1'b0);
        apply(3'b001, 1'b1, 1'b0, 1'b0);
        apply(3'b001, 1'b1, 1'b0, 1'b0);
        apply(3'b010, 1'b1, 1'b0, 1'b0);
        apply(3'b100, 1'b1, 1'b0, 1'b0);
        apply(3'b001, 1'b1, 1'b0, 1'b0);
        apply(3'b100, 1'b1, 1'b0, 1'b0);
        apply(3'b001, 1'b1, 1'b0, 1'b0);
        apply(3'b011, 1'b1, 1'b0, 1'b0);
        apply(3'b010, 1'b1, 1'b0, 1'b0);
        apply(3'b001, 1'b1, 1'b1, 1'b0);
        apply(3'b010, 1'b1, 1'b1, 1'b0);
        apply(3'b010, 1'b0, 1'b0, 1'b0);
        apply(3'b100, 1'b1, 1'b0, 1'b0);
        for (int n = 0; n < 5; n++) begin
            apply(3'b001, 1'b1, 1'b0, 1'b0);
            apply(3'b001, 1'b1, 1'b0, 1'b0);
            apply(3'b010, 1'b1, 1'b0, 1'b0);
            apply(3'b010, 1'b1, 1'b0, 1'b0);
            apply(3'b100, 1'b1, 1'b0, 1'b0);
            apply(3'b100, 1'b1, 1'b0, 1'b0);
        end
        apply(3'b010, 1'b1, 1'b0, 1'b1);
        apply(3'b010, 1'b1, 1'b0, 1'b0);
        for (int n = 0; n < 1500; n++) begin
            k = $urandom_range(0, 19);
            base = m_lock[0] ? m_cur[0] : int'($urandom_range(0, 2));
            apply(k < 10 ? onehot((base + 1) % 3) :
                  k < 14 ? onehot(base) :
                  k < 16 ? onehot((base + 2) % 3) :
                  k < 18 ? bad[$urandom_range(0, 4)] : 3'($urandom),
                  $urandom_range(0, 29) != 0, $urandom_range(0, 7) == 0,
                  $urandom_range(0, 299) == 0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
